fft_share_arb: RTL and testbench
================================

Name: fft_share_arb

Overview:
- Time-multiplexes one fft8 core between the transmit IFFT path (tx) and the receive FFT path (rx).
- Decides which requester's 8-point block enters the core each cycle.
- Drives the core enable and the external operand-mux select.
- Tracks every in-flight block through the core's pipeline so each core valid pulse is routed back to the requester that issued it.
- Sits between the hermitian stages and the shared fft8 instance in the OFDM chain.

Parameters:
- LAT, 3, cycles from core_en asserted to the matching core_valid; legal range 1-15.
- II, 1, minimum cycles between two core_en pulses (initiation interval); legal range 1-15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_tx  in  1  tx block ready; held high with data stable until gnt_tx
- req_rx  in  1  rx block ready; held high with data stable until gnt_rx
- gnt_tx  out  1  combinational; core samples tx operands this cycle
- gnt_rx  out  1  combinational; core samples rx operands this cycle
- core_en  out  1  gnt_tx | gnt_rx; drives fft8 en
- core_sel  out  1  operand mux select; 0 = tx, 1 = rx; valid when core_en = 1, otherwise holds its last value
- core_valid  in  1  fft8 valid
- done_tx  out  1  core_valid & head entry valid & head tag = tx
- done_rx  out  1  core_valid & head entry valid & head tag = rx
- busy  out  1  at least one block in flight
- err_orphan  out  1  sticky; core_valid seen with no tracked block
- err_miss  out  1  sticky; tracked block reached head without core_valid

Behaviour:
Reset (asynchronous, active low):
- Clears the tag pipeline, gap counter, last-grant pointer (set to rx, so tx wins the first tie) and both error flags.
- While reset is low: all grant and done outputs are 0, busy = 0, core_sel = 0.
- Reset asserted mid-operation discards all in-flight tags. core_valid pulses that arrive afterwards raise err_orphan; this is intended.

Grant eligibility:
- Grants are allowed only when the gap counter is 0.
- On each grant the gap counter loads II-1, then decrements to 0. With II = 1 a grant is possible every cycle.

Arbitration (combinational, when eligible):
- Only one requester asserted: that requester is granted.
- Both asserted: the requester not granted last is granted (round robin). The pointer updates on every grant.
- Neither asserted: no grant.
- At most one of gnt_tx / gnt_rx is high in any cycle.

Requester side:
- A requester that keeps req high after a grant re-competes from the next eligible cycle.
- Back-to-back blocks from one requester are allowed when the other requester is idle.

Tag pipeline (LAT-entry shift register of {vld, tag}):
- Entry 0 loads {core_en, core_sel} every cycle.
- Entry LAT-1 is the head and is compared against core_valid in the same cycle.
- Each block therefore reaches the head exactly LAT cycles after its grant.
- Routing at the head:
  - head.vld & core_valid: one done pulse, selected by head.tag.
  - core_valid & !head.vld: set err_orphan; no done pulse.
  - head.vld & !core_valid: set err_miss; the tag is dropped.

busy:
- busy = OR of all entry vld bits.
- It goes high the cycle after a grant and falls the cycle after the last head consumption.

Latency and throughput:
- Grant to done is LAT cycles.
- Maximum throughput is one block per II cycles, shared between the two requesters.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds outputs cnt_tx[15:0] and cnt_rx[15:0].
  - Each counts grants to its requester.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Input stats_clr (1 bit, synchronous) zeroes both counters. If stats_clr coincides with a grant, the clear wins and the count is 0.
- Not defined: these ports and registers are absent; all other behaviour is unchanged.

Test Plan:
1. Reset, then req_tx high for 1 cycle only (LAT = 3, II = 1) -> gnt_tx the same cycle, core_sel = 0, busy high for cycles 1-3; drive core_valid at cycle 3 -> done_tx = 1 at cycle 3, done_rx = 0.
2. req_tx and req_rx both held high for 6 cycles -> grants alternate tx, rx, tx, rx, tx, rx (tx first after reset); done pulses follow 3 cycles later in the same order.
3. II = 4, req_rx held high for 12 cycles -> gnt_rx at cycles 0, 4 and 8 only; core_en never high on two cycles less than 4 apart.
4. core_valid pulsed with no outstanding grant -> err_orphan = 1 and stays set; no done pulse; err_miss = 0.
5. gnt_tx issued, core_valid withheld -> err_miss = 1 at cycle LAT; busy = 0 on the following cycle.
6. Both requests active, reset pulled low for 1 cycle at cycle 2 -> outputs 0 immediately, busy = 0; tx is granted first after reset release. With ARB_STATS_EN: 5 tx grants -> cnt_tx = 5; stats_clr -> cnt_tx = 0.

Source files
------------

// File: rtl/fft_share_arb.sv
// fft_share_arb: shares one fft8 core between the tx IFFT path and the rx FFT
// path. Round-robin grant with an initiation-interval gap, plus a LAT-deep tag
// pipeline that routes each core_valid back to the requester that issued it.
// Optional grant counters are built when ARB_STATS_EN is defined.
module fft_share_arb #(
  parameter int LAT = 3,  // core_en to core_valid latency, 1..15
  parameter int II  = 1   // minimum cycles between core_en pulses, 1..15
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active low
  input  logic        req_tx,
  input  logic        req_rx,
  output logic        gnt_tx,
  output logic        gnt_rx,
  output logic        core_en,
  output logic        core_sel,
  input  logic        core_valid,
  output logic        done_tx,
  output logic        done_rx,
  output logic        busy,
  output logic        err_orphan,
  output logic        err_miss
`ifdef ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] cnt_tx,
  output logic [15:0] cnt_rx
`endif
);

  localparam logic [3:0] GAP_LOAD = 4'(II - 1);

  logic [3:0]     r_gap;
  logic           r_last_rx;   // 1: last grant went to rx, so tx wins a tie
  logic           r_sel;       // core_sel value held between grants
  logic [LAT-1:0] r_vld;
  logic [LAT-1:0] r_tag;       // 0 = tx, 1 = rx
  logic           r_err_orphan;
  logic           r_err_miss;

  logic w_elig;
  logic w_pick_rx;
  logic w_head_vld;
  logic w_head_tag;
  logic w_orphan_now;
  logic w_miss_now;

  // Grant eligibility and round-robin choice; reset forces every grant low
  always_comb begin
    w_elig    = reset & (r_gap == 4'd0);
    w_pick_rx = req_rx & (~req_tx | ~r_last_rx);
    gnt_rx    = w_elig & w_pick_rx;
    gnt_tx    = w_elig & req_tx & ~w_pick_rx;
    core_en   = gnt_tx | gnt_rx;
    core_sel  = core_en ? gnt_rx : r_sel;
  end

  // Head-of-pipeline routing against core_valid
  always_comb begin
    w_head_vld   = r_vld[LAT-1];
    w_head_tag   = r_tag[LAT-1];
    done_tx      = core_valid & w_head_vld & ~w_head_tag;
    done_rx      = core_valid & w_head_vld &  w_head_tag;
    w_orphan_now = reset & core_valid & ~w_head_vld;
    w_miss_now   = w_head_vld & ~core_valid;
    busy         = |r_vld;
    // Error outputs show the event in the cycle it happens, then stay set
    err_orphan   = r_err_orphan | w_orphan_now;
    err_miss     = r_err_miss | w_miss_now;
  end

  // Gap counter, round-robin pointer and held operand select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap     <= 4'd0;
      r_last_rx <= 1'b1;
      r_sel     <= 1'b0;
    end else if (core_en) begin
      r_gap     <= GAP_LOAD;
      r_last_rx <= gnt_rx;
      r_sel     <= gnt_rx;
    end else if (r_gap != 4'd0) begin
      r_gap     <= r_gap - 4'd1;
    end
  end

  // Tag pipeline: entry 0 captures this cycle's grant, each entry shifts on
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        // First stage takes the current grant
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_vld[0] <= 1'b0;
            r_tag[0] <= 1'b0;
          end else begin
            r_vld[0] <= core_en;
            r_tag[0] <= core_sel;
          end
        end
      end else begin : g_shift
        // Later stages advance the tag one step per cycle
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_vld[gi] <= 1'b0;
            r_tag[gi] <= 1'b0;
          end else begin
            r_vld[gi] <= r_vld[gi-1];
            r_tag[gi] <= r_tag[gi-1];
          end
        end
      end
    end
  endgenerate

  // Sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_orphan <= 1'b0;
      r_err_miss   <= 1'b0;
    end else begin
      if (w_orphan_now) r_err_orphan <= 1'b1;
      if (w_miss_now)   r_err_miss   <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_cnt_tx;
  logic [15:0] r_cnt_rx;

  // Saturating grant counters; a clear overrides a simultaneous grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_tx <= 16'd0;
      r_cnt_rx <= 16'd0;
    end else if (stats_clr) begin
      r_cnt_tx <= 16'd0;
      r_cnt_rx <= 16'd0;
    end else begin
      if (gnt_tx && r_cnt_tx != 16'hFFFF) r_cnt_tx <= r_cnt_tx + 16'd1;
      if (gnt_rx && r_cnt_rx != 16'hFFFF) r_cnt_rx <= r_cnt_rx + 16'd1;
    end
  end

  assign cnt_tx = r_cnt_tx;
  assign cnt_rx = r_cnt_rx;
`endif

endmodule

// File: tb/tb_fft_share_arb.sv
// Directed bench for fft_share_arb: LAT = 3 with II = 1 (u_dut) and II = 4
// (u_dut_ii4). Inputs change 1 ns after a rising edge, outputs are sampled
// 1 ns later, well away from the next edge.
module tb_fft_share_arb;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic req_tx = 1'b0, req_rx = 1'b0, core_valid = 1'b0;
  logic gnt_tx, gnt_rx, core_en, core_sel, done_tx, done_rx, busy, err_orphan, err_miss;

  logic req_tx4 = 1'b0, req_rx4 = 1'b0, core_valid4 = 1'b0;
  logic gnt_tx4, gnt_rx4, core_en4, core_sel4, done_tx4, done_rx4, busy4, err_orphan4, err_miss4;

`ifdef ARB_STATS_EN
  logic        stats_clr = 1'b0, stats_clr4 = 1'b0;
  logic [15:0] cnt_tx, cnt_rx, cnt_tx4, cnt_rx4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_share_arb #(.LAT(3), .II(1)) u_dut (
    .clk(clk), .reset(reset), .req_tx(req_tx), .req_rx(req_rx),
    .gnt_tx(gnt_tx), .gnt_rx(gnt_rx), .core_en(core_en), .core_sel(core_sel),
    .core_valid(core_valid), .done_tx(done_tx), .done_rx(done_rx), .busy(busy),
    .err_orphan(err_orphan), .err_miss(err_miss)
`ifdef ARB_STATS_EN
    , .stats_clr(stats_clr), .cnt_tx(cnt_tx), .cnt_rx(cnt_rx)
`endif
  );

  fft_share_arb #(.LAT(3), .II(4)) u_dut_ii4 (
    .clk(clk), .reset(reset), .req_tx(req_tx4), .req_rx(req_rx4),
    .gnt_tx(gnt_tx4), .gnt_rx(gnt_rx4), .core_en(core_en4), .core_sel(core_sel4),
    .core_valid(core_valid4), .done_tx(done_tx4), .done_rx(done_rx4), .busy(busy4),
    .err_orphan(err_orphan4), .err_miss(err_miss4)
`ifdef ARB_STATS_EN
    , .stats_clr(stats_clr4), .cnt_tx(cnt_tx4), .cnt_rx(cnt_rx4)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, release 1 ns after an edge; caller is in cycle 0
  task automatic do_reset();
    reset = 1'b0;
    req_tx = 1'b0; req_rx = 1'b0; core_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Watchdog: the sequence uses only fixed cycle counts, so this is a backstop
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- Test 1: reset state, then a single tx block ----
    reset = 1'b0; req_tx = 1'b1; req_rx = 1'b1; core_valid = 1'b1;
    #2;
    check("rst gnt_tx", int'(gnt_tx), 0);
    check("rst gnt_rx", int'(gnt_rx), 0);
    check("rst core_en", int'(core_en), 0);
    check("rst core_sel", int'(core_sel), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'({done_tx, done_rx}), 0);
    check("rst err_orphan", int'(err_orphan), 0);
    do_reset();
    req_tx = 1'b1; #1;
    check("t1 c0 gnt_tx", int'(gnt_tx), 1);
    check("t1 c0 core_sel", int'(core_sel), 0);
    check("t1 c0 busy", int'(busy), 0);
    next_cycle(); req_tx = 1'b0; #1;
    check("t1 c1 busy", int'(busy), 1);
    check("t1 c1 core_en", int'(core_en), 0);
    next_cycle(); #1;
    check("t1 c2 busy", int'(busy), 1);
    next_cycle(); core_valid = 1'b1; #1;
    check("t1 c3 done_tx", int'(done_tx), 1);
    check("t1 c3 done_rx", int'(done_rx), 0);
    check("t1 c3 busy", int'(busy), 1);
    next_cycle(); core_valid = 1'b0; #1;
    check("t1 c4 busy", int'(busy), 0);
    check("t1 c4 err_miss", int'(err_miss), 0);
    check("t1 c4 err_orphan", int'(err_orphan), 0);

    // ---- Test 2: both requesting for 6 cycles, alternation and done order ----
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      req_tx = (c < 6); req_rx = (c < 6);
      core_valid = (c >= 3 && c < 9);
      #1;
      check($sformatf("t2 c%0d gnt_tx", c), int'(gnt_tx), (c < 6 && c % 2 == 0) ? 1 : 0);
      check($sformatf("t2 c%0d gnt_rx", c), int'(gnt_rx), (c < 6 && c % 2 == 1) ? 1 : 0);
      check($sformatf("t2 c%0d done_tx", c), int'(done_tx), (c >= 3 && c < 9 && c % 2 == 1) ? 1 : 0);
      check($sformatf("t2 c%0d done_rx", c), int'(done_rx), (c >= 3 && c < 9 && c % 2 == 0) ? 1 : 0);
    end
    core_valid = 1'b0;
    check("t2 err_miss", int'(err_miss), 0);
    check("t2 err_orphan", int'(err_orphan), 0);
    check("t2 busy", int'(busy), 0);

    // ---- Test 3: II = 4, rx held for 12 cycles ----
    for (int c = 0; c < 13; c++) begin
      if (c > 0) next_cycle();
      req_rx4 = (c < 12);
      #1;
      check($sformatf("t3 c%0d gnt_rx", c), int'(gnt_rx4), (c < 12 && c % 4 == 0) ? 1 : 0);
      check($sformatf("t3 c%0d core_en", c), int'(core_en4), (c < 12 && c % 4 == 0) ? 1 : 0);
    end
    req_rx4 = 1'b0;

    // ---- Test 4: orphan core_valid ----
    do_reset();
    core_valid = 1'b1; #1;
    check("t4 c0 done", int'({done_tx, done_rx}), 0);
    check("t4 c0 err_orphan", int'(err_orphan), 1);
    next_cycle(); core_valid = 1'b0; #1;
    check("t4 c1 err_orphan", int'(err_orphan), 1);
    check("t4 c1 err_miss", int'(err_miss), 0);
    next_cycle(); next_cycle(); #1;
    check("t4 c3 err_orphan", int'(err_orphan), 1);

    // ---- Test 5: missing core_valid ----
    do_reset();
    req_tx = 1'b1; #1;
    check("t5 c0 gnt_tx", int'(gnt_tx), 1);
    next_cycle(); req_tx = 1'b0; #1;
    check("t5 c1 err_miss", int'(err_miss), 0);
    next_cycle(); next_cycle(); #1;
    check("t5 c3 err_miss", int'(err_miss), 1);
    check("t5 c3 done_tx", int'(done_tx), 0);
    check("t5 c3 busy", int'(busy), 1);
    next_cycle(); #1;
    check("t5 c4 busy", int'(busy), 0);
    check("t5 c4 err_miss", int'(err_miss), 1);
    check("t5 c4 err_orphan", int'(err_orphan), 0);

    // ---- Test 6: reset mid-operation ----
    do_reset();
    req_tx = 1'b1; req_rx = 1'b1; #1;
    check("t6 c0 gnt_tx", int'(gnt_tx), 1);
    next_cycle(); #1;
    check("t6 c1 gnt_rx", int'(gnt_rx), 1);
    next_cycle(); reset = 1'b0; #1;
    check("t6 c2 grants", int'({gnt_tx, gnt_rx}), 0);
    check("t6 c2 core_en", int'(core_en), 0);
    check("t6 c2 core_sel", int'(core_sel), 0);
    check("t6 c2 busy", int'(busy), 0);
    next_cycle(); reset = 1'b1; #1;
    check("t6 c3 gnt_tx", int'(gnt_tx), 1);
    check("t6 c3 gnt_rx", int'(gnt_rx), 0);
    next_cycle(); #1;
    check("t6 c4 gnt_rx", int'(gnt_rx), 1);
    check("t6 c4 core_sel", int'(core_sel), 1);
    next_cycle(); req_tx = 1'b0; req_rx = 1'b0; #1;
    check("t6 c5 core_sel held", int'(core_sel), 1);

`ifdef ARB_STATS_EN
    // ---- Grant counters: 5 back-to-back tx grants, then clear with a grant ----
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      req_tx = 1'b1; #1;
    end
    next_cycle(); req_tx = 1'b0; #1;
    check("st cnt_tx", int'(cnt_tx), 5);
    check("st cnt_rx", int'(cnt_rx), 0);
    next_cycle(); stats_clr = 1'b1; req_tx = 1'b1; #1;
    check("st clr gnt_tx", int'(gnt_tx), 1);
    next_cycle(); stats_clr = 1'b0; req_tx = 1'b0; #1;
    check("st cnt_tx clr", int'(cnt_tx), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
